// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response bundle between the issue sequencer and its environment.
// master = sequencer side; slave = requester/ALU/consumer side.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;

    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [4:0]  alu_sr_amount;
    logic [14:0] alu_op;
    logic [31:0] alu_result;
    logic        alu_zlc;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_zlc;
    logic        resp_illegal;
    logic        resp_div_zero;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_shamt,
        output req_ready,
        output alu_operand1, alu_operand2, alu_sr_amount, alu_op,
        input  alu_result, alu_zlc,
        output resp_valid, resp_result, resp_zlc, resp_illegal, resp_div_zero,
        input  resp_ready
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_shamt,
        input  req_ready,
        input  alu_operand1, alu_operand2, alu_sr_amount, alu_op,
        output alu_result, alu_zlc,
        input  resp_valid, resp_result, resp_zlc, resp_illegal, resp_div_zero,
        output resp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// One-hot ALU issue controller: response after 1+lat cycles (1 for bypassed ops).
// Accepts only in IDLE without flush; response held until resp_ready.
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 34
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    alu_op_sequencer_if.master  bus,
    output logic                o_busy,
    output logic [15:0]         o_done_count
);
    localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_ILL = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_shamt;
    logic [31:0] r_result;
    logic        r_zlc, r_illegal, r_div_zero;
    logic [15:0] r_done_count;

    logic          w_accept, w_illegal, w_div_zero, w_bypass, w_resp_hs;
    logic [CW-1:0] w_cnt_init;

    assign w_accept   = bus.req_valid && bus.req_ready;
    assign w_illegal  = (bus.req_op == OP_ILL);
    assign w_div_zero = ((bus.req_op == OP_DIV) || (bus.req_op == OP_MOD)) && (bus.req_b == 32'd0);
    assign w_bypass   = w_illegal || w_div_zero;
    assign w_resp_hs  = (r_state == S_DONE) && bus.resp_ready && !i_flush;

    always_comb begin
        w_cnt_init = '0;
        if (bus.req_op == OP_MUL)
            w_cnt_init = CW'(MUL_CYCLES - 1);
        else if ((bus.req_op == OP_DIV) || (bus.req_op == OP_MOD))
            w_cnt_init = CW'(DIV_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Flush overrides every transition, including an accept in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.req_valid) w_state_nxt = w_bypass ? S_DONE : S_EXEC;
                S_EXEC:  if (r_cnt == '0)   w_state_nxt = S_DONE;
                S_DONE:  if (bus.resp_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_shamt      <= '0;
            r_result     <= '0;
            r_zlc        <= 1'b0;
            r_illegal    <= 1'b0;
            r_div_zero   <= 1'b0;
            r_done_count <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= bus.req_op;
                r_a        <= bus.req_a;
                r_b        <= bus.req_b;
                r_shamt    <= bus.req_shamt;
                r_cnt      <= w_cnt_init;
                r_zlc      <= 1'b0;
                r_illegal  <= w_illegal;
                r_div_zero <= w_div_zero && !w_illegal;
                if (w_div_zero)
                    r_result <= (bus.req_op == OP_DIV) ? 32'hFFFF_FFFF : bus.req_a;
                else
                    r_result <= 32'd0;
            end
            if ((r_state == S_EXEC) && !i_flush) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_result <= bus.alu_result;
                    r_zlc    <= bus.alu_zlc;
                end
            end
            if (w_resp_hs)
                r_done_count <= r_done_count + 16'd1;
        end
    end

    // Strobe is a pure decode of state, so it can never outlive EXEC.
    assign bus.alu_op        = (r_state == S_EXEC) ? (15'b1 << r_op) : 15'd0;
    assign bus.alu_operand1  = r_a;
    assign bus.alu_operand2  = r_b;
    assign bus.alu_sr_amount = r_shamt;
    assign bus.req_ready     = (r_state == S_IDLE) && !i_flush;
    assign bus.resp_valid    = (r_state == S_DONE);
    assign bus.resp_result   = r_result;
    assign bus.resp_zlc      = r_zlc;
    assign bus.resp_illegal  = r_illegal;
    assign bus.resp_div_zero = r_div_zero;
    assign o_busy            = (r_state != S_IDLE);
    assign o_done_count      = r_done_count;
endmodule
